// File: rtl/alu_wide_sequencer.sv
// Runs 8-bit add/sub/and/or as a sequence of passes through an external 4-bit ALU.
// For add/sub, a fix-up pass folds the low-nibble carry/borrow into the high nibble.
module alu_wide_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] op;
  logic [7:0] a, b;
  logic [3:0] res_lo, res_hi;
  logic       c_lo, c_hi;
  logic [7:0] fin;
  logic       fin_c, fin_ld;

  // The last pass of an op produces the high nibble straight from the ALU.
  assign fin    = {alu_out, res_lo};
  assign fin_c  = (state == FIX) && (c_hi || alu_carry);
  assign fin_ld = (state == FIX) || ((state == HI) && op[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      a          <= '0;
      b          <= '0;
      res_lo     <= '0;
      res_hi     <= '0;
      c_lo       <= 1'b0;
      c_hi       <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      ops_done   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op <= req_op;
        a  <= req_a;
        b  <= req_b;
      end
      if (state == LO) begin
        res_lo <= alu_out;
        c_lo   <= alu_carry;
      end
      if (state == HI) begin
        res_hi <= alu_out;
        c_hi   <= alu_carry;
      end
      if (state == FIX) res_hi <= alu_out;
      if (fin_ld) begin
        rsp_result <= fin;
        rsp_carry  <= fin_c;
        rsp_zero   <= (fin == 8'h00);
        rsp_sign   <= fin[7];
      end
      if (state == DONE && rsp_ready) ops_done <= ops_done + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = LO;
      LO:      state_nx = HI;
      HI:      state_nx = op[1] ? DONE : FIX;
      FIX:     state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    case (state)
      LO: begin
        alu_a   = a[3:0];
        alu_b   = b[3:0];
        alu_sel = op;
      end
      HI: begin
        alu_a   = a[7:4];
        alu_b   = b[7:4];
        alu_sel = op;
      end
      FIX: begin
        alu_a   = res_hi;
        alu_b   = {3'b000, c_lo};
        alu_sel = op;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench: a plain-arithmetic model of the 8-bit op, latency and pass
// sequence is compared every cycle, plus literal expectations per vector.
module tb_alu_wide_sequencer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [7:0]       req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry, rsp_zero, rsp_sign;
  logic [3:0]       alu_a, alu_b, alu_out;
  logic [1:0]       alu_sel;
  logic             alu_carry;
  logic [CNT_W-1:0] ops_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .ops_done(ops_done)
  );

  // The team's 4-bit ALU
  logic [4:0] r5;
  always_comb begin
    r5 = 5'd0;
    case (alu_sel)
      2'b00: r5 = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: r5 = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: r5 = {1'b0, alu_a & alu_b};
      2'b11: r5 = {1'b0, alu_a | alu_b};
      default: ;
    endcase
    alu_out   = r5[3:0];
    alu_carry = r5[4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding op, results from whole-byte arithmetic.
  logic       m_busy, m_valid;
  int         m_cnt, m_tot, m_ops;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b, m_res;
  logic       m_c;

  function automatic logic [8:0] byte_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'b00:   return {1'b0, x} + {1'b0, y};
      2'b01:   return {(x < y), x - y};
      2'b10:   return {1'b0, x & y};
      default: return {1'b0, x | y};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_tot <= 0; m_ops <= 0;
      m_op <= 2'b00; m_a <= 8'h00; m_b <= 8'h00; m_res <= 8'h00; m_c <= 1'b0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
        m_ops   <= (m_ops + 1) % (1 << CNT_W);
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (req_valid) begin
      m_busy <= 1'b1;
      m_op   <= req_op;
      m_a    <= req_a;
      m_b    <= req_b;
      m_tot  <= req_op[1] ? 2 : 3;
      m_cnt  <= req_op[1] ? 2 : 3;
      {m_c, m_res} <= byte_op(req_op, req_a, req_b);
    end
  end

  // Expected ALU drive for the pass the model is in.
  function automatic logic [9:0] exp_alu();
    logic [3:0] hi;
    logic       clo;
    int         p;
    if (!m_busy || m_valid) return 10'd0;
    p   = m_tot - m_cnt;
    hi  = (m_op == 2'b00) ? (m_a[7:4] + m_b[7:4]) : (m_a[7:4] - m_b[7:4]);
    clo = (m_op == 2'b00) ? ({1'b0, m_a[3:0]} + {1'b0, m_b[3:0]} > 5'd15) : (m_a[3:0] < m_b[3:0]);
    case (p)
      0:       return {m_a[3:0], m_b[3:0], m_op};
      1:       return {m_a[7:4], m_b[7:4], m_op};
      default: return {hi, 3'b000, clo, m_op};
    endcase
  endfunction

  always @(negedge clk) begin
    check("req_ready", req_ready, !m_busy);
    check("rsp_valid", rsp_valid, m_valid);
    check("ops_done", ops_done, m_ops);
    check("alu_drive", {alu_a, alu_b, alu_sel}, exp_alu());
    if (m_valid) begin
      check("rsp_result", rsp_result, m_res);
      check("rsp_carry", rsp_carry, m_c);
      check("rsp_zero", rsp_zero, m_res == 8'h00);
      check("rsp_sign", rsp_sign, m_res[7]);
    end
  end

  logic [9:0] trace [0:3];

  task automatic run_op(input string nm, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input int elat, input int hold);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) trace[i] = '0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (k < 4) trace[k] = {alu_a, alu_b, alu_sel};
      k++;
      if (k > 8) break;
    end
    check({nm, " latency"}, k, elat);
    check({nm, " result"}, rsp_result, er);
    check({nm, " carry"}, rsp_carry, ec);
    check({nm, " zero"}, rsp_zero, er == 8'h00);
    check({nm, " sign"}, rsp_sign, er[7]);
    if (hold > 0) begin
      req_valid = 1'b1; req_op = 2'b11; req_a = 8'h55; req_b = 8'hAA;
      repeat (hold) begin
        @(negedge clk);
        check({nm, " held result"}, rsp_result, er);
        check({nm, " held valid"}, rsp_valid, 1'b1);
        check({nm, " held ready"}, req_ready, 1'b0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check({nm, " back idle"}, req_ready, 1'b1);
    check({nm, " valid drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign}, 32'd0);
    check("reset alu", {alu_a, alu_b, alu_sel}, 32'd0);
    check("reset ops_done", ops_done, 32'd0);
    rst = 1'b0;

    run_op("add3c0f", 2'b00, 8'h3C, 8'h0F, 8'h4B, 1'b0, 3, 0);
    check("add3c0f pass LO", trace[0], {4'hC, 4'hF, 2'b00});
    check("add3c0f pass HI", trace[1], {4'h3, 4'h0, 2'b00});
    check("add3c0f pass FIX", trace[2], {4'h3, 4'h1, 2'b00});
    run_op("addff01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 3, 0);
    check("addff01 FIX pass", trace[2], {4'hF, 4'h1, 2'b00});
    run_op("sub1001", 2'b01, 8'h10, 8'h01, 8'h0F, 1'b0, 3, 0);
    run_op("sub0001", 2'b01, 8'h00, 8'h01, 8'hFF, 1'b1, 3, 0);
    run_op("andf03c", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 2, 0);
    check("and no FIX", trace[2], 10'd0);
    run_op("or0fa0", 2'b11, 8'h0F, 8'hA0, 8'hAF, 1'b0, 2, 0);
    check("ops_done after 6", ops_done, 32'd2);

    run_op("bp add", 2'b00, 8'h7E, 8'h05, 8'h83, 1'b0, 3, 5);
    check("ops_done after bp", ops_done, 32'd3);

    // Abort an add while it is in its HI pass.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 8'h12; req_b = 8'h34; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset HI pass", {alu_a, alu_b, alu_sel}, {4'h1, 4'h3, 2'b00});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort req_ready", req_ready, 1'b1);
    check("abort rsp_valid", rsp_valid, 1'b0);
    check("abort ops_done", ops_done, 32'd0);
    check("abort alu", {alu_a, alu_b, alu_sel}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort no rsp", rsp_valid, 1'b0);
    end

    run_op("w1", 2'b00, 8'h01, 8'h02, 8'h03, 1'b0, 3, 0);
    run_op("w2", 2'b01, 8'h05, 8'h07, 8'hFE, 1'b1, 3, 0);
    run_op("w3", 2'b10, 8'hAA, 8'h0F, 8'h0A, 1'b0, 2, 0);
    check("ops_done 3", ops_done, 32'd3);
    run_op("w4", 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 2, 0);
    check("ops_done wrap", ops_done, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
